// File: rtl/victory_sprite_renderer.sv
// ---------------------------------------------------------------------------
// victory_sprite_renderer
//
// Draws the 11x11 trophy bitmap of the end-of-game screen at (POS_X, POS_Y),
// each bitmap cell SCALE x SCALE pixels. The sprite blinks between COLOR_A
// and COLOR_B every BLINK_FRAMES frames. Optionally it bounces vertically.
// Cell coordinates come from sub-pixel counters, so no divider is needed.
//
// Optional feature macro:
//   VICTORY_BOUNCE_EN - when defined, the sprite bounces 0..BOUNCE_AMP pixels
//                       downward in a triangle wave (one pixel per frame).
//
// Ports:
//   clk        in   pixel clock
//   reset      in   synchronous, active-high reset
//   enable     in   victory screen active
//   h_counter  in   [9:0] current pixel column (advances by 1 per clk in a line)
//   v_counter  in   [9:0] current line
//   R, G, B    out  [7:0] pixel colour, 0 outside the lit sprite cells
//   sprite_hit out  pixel belongs to a lit bitmap cell
//
// Latency: a pixel presented at cycle N appears on the outputs at cycle N+2.
// ---------------------------------------------------------------------------
module victory_sprite_renderer #(
    parameter int          SCALE        = 10,
    parameter int          POS_X        = 400,
    parameter int          POS_Y        = 200,
    parameter int          BLINK_FRAMES = 30,
    parameter int          BOUNCE_AMP   = 16,
    parameter logic [23:0] COLOR_A      = 24'hFFFF00,
    parameter logic [23:0] COLOR_B      = 24'hFFFFFF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic [9:0] h_counter,
    input  logic [9:0] v_counter,
    output logic [7:0] R,
    output logic [7:0] G,
    output logic [7:0] B,
    output logic       sprite_hit
);

    localparam int          SPAN      = 11 * SCALE;
    localparam logic [10:0] X_LO      = 11'(POS_X);
    localparam logic [10:0] X_HI      = 11'(POS_X + SPAN);
    localparam logic [10:0] Y_BASE    = 11'(POS_Y);
    localparam logic [10:0] Y_SPAN    = 11'(SPAN);
    localparam logic [4:0]  SUB_MAX   = 5'(SCALE - 1);
    localparam int          FCNT_W    = (2 * BLINK_FRAMES > 1) ? $clog2(2 * BLINK_FRAMES) : 1;
    localparam logic [FCNT_W-1:0] FCNT_LAST = FCNT_W'(2 * BLINK_FRAMES - 1);
    localparam logic [FCNT_W-1:0] FCNT_HALF = FCNT_W'(BLINK_FRAMES);

    // Placement that runs off the bottom of the 480-line screen (at maximum
    // bounce) or an unsupported scale is a configuration error.
    if ((POS_Y + BOUNCE_AMP + SPAN > 480) || (SCALE < 1) || (SCALE > 31)) begin : g_bad_config
        $error("victory_sprite_renderer: illegal SCALE or sprite leaves the visible area");
    end

    // Lit columns of one bitmap row (bit c = column c).
    function automatic logic [10:0] bitmap_row(input logic [3:0] r);
        case (r)
            4'd0, 4'd5, 4'd10:       bitmap_row = 11'h1FC;
            4'd1, 4'd4:              bitmap_row = 11'h7FF;
            4'd2, 4'd3:              bitmap_row = 11'h5FD;
            4'd6, 4'd7, 4'd8, 4'd9:  bitmap_row = 11'h070;
            default:                 bitmap_row = 11'h000;
        endcase
    endfunction

    logic [10:0] h_ext;
    logic [10:0] v_ext;
    logic        frame_start;
    logic        line_start;

    assign h_ext       = {1'b0, h_counter};
    assign v_ext       = {1'b0, v_counter};
    assign line_start  = (h_counter == 10'd0);
    assign frame_start = line_start && (v_counter == 10'd0);

    // ------------------------------------------------------------------
    // Per-frame state: blink counter, bounce offset, latched origin/colour
    // ------------------------------------------------------------------
    logic [FCNT_W-1:0] fcnt_reg;
    logic [10:0]       y0_reg;
    logic              phase_b_reg;
    logic [10:0]       y0_frame;   // origin for a frame beginning on this cycle
    logic [10:0]       y0_cur;
    logic              phase_b_cur;

`ifdef VICTORY_BOUNCE_EN
    logic [9:0] off_reg;
    logic       dir_up_reg;   // 0: offset growing (sprite moving down)

    assign y0_frame = Y_BASE + {1'b0, off_reg};

    always_ff @(posedge clk) begin
        if (reset || !enable) begin
            off_reg    <= 10'd0;
            dir_up_reg <= 1'b0;
        end else if (frame_start && (BOUNCE_AMP > 0)) begin
            if (!dir_up_reg) begin
                off_reg <= off_reg + 10'd1;
                if (off_reg + 10'd1 == 10'(BOUNCE_AMP)) begin
                    dir_up_reg <= 1'b1;
                end
            end else begin
                off_reg <= off_reg - 10'd1;
                if (off_reg == 10'd1) begin
                    dir_up_reg <= 1'b0;
                end
            end
        end
    end
`else
    assign y0_frame = Y_BASE;
`endif

    // The frame-start pixel itself already belongs to the new frame, so the
    // freshly sampled values are forwarded on that cycle.
    assign y0_cur      = frame_start ? y0_frame : y0_reg;
    assign phase_b_cur = frame_start ? (fcnt_reg >= FCNT_HALF) : phase_b_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            fcnt_reg    <= '0;
            y0_reg      <= Y_BASE;
            phase_b_reg <= 1'b0;
        end else begin
            if (frame_start) begin
                y0_reg      <= y0_cur;
                phase_b_reg <= phase_b_cur;
            end
            if (!enable) begin
                fcnt_reg <= '0;
            end else if (frame_start) begin
                fcnt_reg <= (fcnt_reg == FCNT_LAST) ? '0 : fcnt_reg + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Column tracking: registers hold the cell state for the current pixel,
    // with the left edge forcing a restart.
    // ------------------------------------------------------------------
    logic [3:0] col_reg;
    logic [4:0] hsub_reg;
    logic [3:0] col_cur;
    logic [4:0] hsub_cur;
    logic       in_x;

    assign in_x = (h_ext >= X_LO) && (h_ext < X_HI);

    always_comb begin
        col_cur  = col_reg;
        hsub_cur = hsub_reg;
        if (h_ext == X_LO) begin
            col_cur  = 4'd0;
            hsub_cur = 5'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            col_reg  <= 4'd0;
            hsub_reg <= 5'd0;
        end else if (in_x) begin
            if (hsub_cur == SUB_MAX) begin
                hsub_reg <= 5'd0;
                col_reg  <= col_cur + 4'd1;
            end else begin
                hsub_reg <= hsub_cur + 5'd1;
                col_reg  <= col_cur;
            end
        end
    end

    // ------------------------------------------------------------------
    // Row tracking: advances once per line, on the h_counter==0 cycle.
    // ------------------------------------------------------------------
    logic [3:0] row_reg;
    logic [4:0] vsub_reg;
    logic [3:0] row_ls;
    logic [4:0] vsub_ls;
    logic [3:0] row_cur;
    logic       in_y;

    assign in_y = (v_ext >= y0_cur) && (v_ext < y0_cur + Y_SPAN);

    always_comb begin
        row_ls  = row_reg;
        vsub_ls = vsub_reg;
        if (v_ext == y0_cur) begin
            row_ls  = 4'd0;
            vsub_ls = 5'd0;
        end else if (in_y) begin
            if (vsub_reg == SUB_MAX) begin
                vsub_ls = 5'd0;
                row_ls  = row_reg + 4'd1;
            end else begin
                vsub_ls = vsub_reg + 5'd1;
            end
        end
    end

    assign row_cur = line_start ? row_ls : row_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            row_reg  <= 4'd0;
            vsub_reg <= 5'd0;
        end else if (line_start) begin
            row_reg  <= row_ls;
            vsub_reg <= vsub_ls;
        end
    end

    // ------------------------------------------------------------------
    // Bitmap lookup and two-stage output pipeline
    // ------------------------------------------------------------------
    logic [10:0] row_bits;
    logic        cell_lit;

    assign row_bits = bitmap_row(row_cur);
    assign cell_lit = (col_cur < 4'd11) && row_bits[col_cur];

    logic s1_en_reg;
    logic s1_region_reg;
    logic s1_bit_reg;
    logic s1_phase_b_reg;
    logic s1_hit;

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_en_reg      <= 1'b0;
            s1_region_reg  <= 1'b0;
            s1_bit_reg     <= 1'b0;
            s1_phase_b_reg <= 1'b0;
        end else begin
            s1_en_reg      <= enable;
            s1_region_reg  <= in_x && in_y;
            s1_bit_reg     <= cell_lit;
            s1_phase_b_reg <= phase_b_cur;
        end
    end

    assign s1_hit = s1_en_reg && s1_region_reg && s1_bit_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            sprite_hit <= 1'b0;
            R          <= 8'd0;
            G          <= 8'd0;
            B          <= 8'd0;
        end else begin
            sprite_hit <= s1_hit;
            if (s1_hit) begin
                {R, G, B} <= s1_phase_b_reg ? COLOR_B : COLOR_A;
            end else begin
                {R, G, B} <= 24'd0;
            end
        end
    end

endmodule

// File: tb/tb_victory_sprite_renderer.sv
// ---------------------------------------------------------------------------
// tb_victory_sprite_renderer
//
// Directed bench for victory_sprite_renderer. Two instances share the inputs:
// "dut" with default parameters and "dut_s" with SCALE=3 at the origin.
// Inputs change on the falling edge; registered outputs are read on the
// falling edge, two rising edges after the pixel of interest was presented.
// Expected values in the bounce build follow the triangle wave of the
// VICTORY_BOUNCE_EN configuration.
// ---------------------------------------------------------------------------
module tb_victory_sprite_renderer;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       enable = 1'b0;
    logic [9:0] h_counter = 10'd0;
    logic [9:0] v_counter = 10'd0;

    logic [7:0] r_main, g_main, b_main;
    logic       hit_main;
    logic [7:0] r_s, g_s, b_s;
    logic       hit_s;

    wire [24:0] out_main = {hit_main, r_main, g_main, b_main};
    wire [24:0] out_s    = {hit_s, r_s, g_s, b_s};

    int total = 0;
    int bad   = 0;

    localparam logic [24:0] LIT_A = {1'b1, 24'hFFFF00};
    localparam logic [24:0] LIT_B = {1'b1, 24'hFFFFFF};
    localparam logic [24:0] DARK  = 25'd0;

    // Trophy bitmap, bit c = column c.
    logic [10:0] bm [0:10] = '{11'h1FC, 11'h7FF, 11'h5FD, 11'h5FD, 11'h7FF, 11'h1FC,
                               11'h070, 11'h070, 11'h070, 11'h070, 11'h1FC};
    logic [10:0] rowbits;
    logic [24:0] exp_px;

    always #5 clk = ~clk;

    victory_sprite_renderer dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .h_counter  (h_counter),
        .v_counter  (v_counter),
        .R          (r_main),
        .G          (g_main),
        .B          (b_main),
        .sprite_hit (hit_main)
    );

    victory_sprite_renderer #(.SCALE(3), .POS_X(0), .POS_Y(0)) dut_s (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .h_counter  (h_counter),
        .v_counter  (v_counter),
        .R          (r_s),
        .G          (g_s),
        .B          (b_s),
        .sprite_hit (hit_s)
    );

    // Top edge of the default sprite in frame k after enable rose.
    function automatic int y0_of(input int k);
`ifdef VICTORY_BOUNCE_EN
        int m;
        m = k % 32;
        return 200 + ((m <= 16) ? m : 32 - m);
`else
        return 200 + 0 * k;
`endif
    endfunction

    function automatic logic [24:0] color_of(input int k);
        return ((k % 60) < 30) ? LIT_A : LIT_B;
    endfunction

    task automatic step(input int h, input int v);
        @(negedge clk);
        h_counter = 10'(h);
        v_counter = 10'(v);
    endtask

    task automatic check(input string tag, input logic [24:0] obs, input logic [24:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic advance_lines(input int from, input int upto);
        for (int v = from; v < upto; v++) step(0, v);
    endtask

    // Scan one line from h=0 and check the default instance at two pixels.
    task automatic line_probe(input int v, input int ha, input logic [24:0] ea,
                              input int hb, input logic [24:0] eb, input string tag);
        int hmax;
        hmax = ((ha > hb) ? ha : hb) + 2;
        for (int h = 0; h <= hmax; h++) begin
            step(h, v);
            if (h == ha + 2) check($sformatf("%s(%0d,%0d)", tag, ha, v), out_main, ea);
            if (h == hb + 2) check($sformatf("%s(%0d,%0d)", tag, hb, v), out_main, eb);
        end
        $display("probe %s: v=%0d h=%0d,%0d", tag, v, ha, hb);
    endtask

    // Frame k: the line above the sprite is dark, its top row is lit.
    task automatic top_probe(input int k);
        int y0;
        y0 = y0_of(k);
        step(0, 0);
        advance_lines(1, y0 - 1);
        line_probe(y0 - 1, 430, DARK, 420, DARK, $sformatf("f%0d_above", k));
        line_probe(y0, 430, color_of(k), 419, DARK, $sformatf("f%0d_top", k));
    endtask

    initial begin
        // Reset state
        repeat (3) step(5, 5);
        check("reset_main", out_main, DARK);
        check("reset_s", out_s, DARK);
        check("reset_fcnt", 25'(dut.fcnt_reg), 25'd0);
        reset = 1'b0;
        step(5, 5);
        enable = 1'b1;

        // Frame 0: main function and region edges
        step(0, 0);
        advance_lines(1, 200);
        line_probe(200, 430, LIT_A, 410, DARK, "f0_r0");
        advance_lines(201, 210);
        line_probe(210, 400, LIT_A, 510, DARK, "f0_r1");
        advance_lines(211, 220);
        line_probe(220, 410, DARK, 400, LIT_A, "f0_r2");
        advance_lines(221, 250);
        line_probe(250, 399, DARK, 510, DARK, "f0_r5edge");
        advance_lines(251, 260);
        line_probe(260, 440, LIT_A, 430, DARK, "f0_r6");
        advance_lines(261, 309);
        line_probe(309, 425, LIT_A, 490, DARK, "f0_r10");
        line_probe(310, 509, DARK, 430, DARK, "f0_below");

        // Frames 1..60: blink phases and vertical position
        for (int k = 1; k <= 60; k++) begin
            if (k == 5 || k == 16 || k == 17 || k == 30 || k == 45 || k == 60) top_probe(k);
            else step(0, 0);
        end

        // Frame 61: enable falls mid-line inside the sprite
        begin
            int y0;
            y0 = y0_of(61);
            step(0, 0);
            advance_lines(1, y0);
            for (int h = 0; h <= 432; h++) step(h, y0);
            check("fall_before", out_main, color_of(61));
            check("fall_fcnt_before", 25'(dut.fcnt_reg), 25'd2);
            step(433, y0);
            enable = 1'b0;
            step(434, y0);
            check("fall_plus1", out_main, color_of(61));
            step(435, y0);
            check("fall_plus2", out_main, DARK);
            check("fall_fcnt", 25'(dut.fcnt_reg), 25'd0);
            for (int h = 436; h <= 440; h++) step(h, y0);
            check("fall_after", out_main, DARK);
            $display("enable fall tested on line %0d", y0);
        end

        // Reset pulse during a lit pixel of the small instance
        step(5, 5);
        enable = 1'b1;
        for (int h = 0; h <= 10; h++) step(h, 0);
        check("rst_before", out_s, LIT_A);
        step(11, 0);
        reset = 1'b1;
        step(12, 0);
        check("rst_edge", out_s, DARK);
        reset = 1'b0;
        $display("reset pulse applied at h=11 v=0");

        // Next frame: full 11x11 pattern at SCALE=3
        for (int v = 0; v <= 32; v++) begin
            for (int h = 0; h <= 34; h++) begin
                step(h, v);
                if (h >= 2) begin
                    rowbits = bm[v / 3];
                    exp_px  = rowbits[(h - 2) / 3] ? LIT_A : DARK;
                    check($sformatf("redraw(%0d,%0d)", h - 2, v), out_s, exp_px);
                end
            end
            $display("redraw line %0d checked", v);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
